// File: rtl/ram_pack_pkg.sv
// Shared types and width helpers for the packed-chunk RAM writer.
package ram_pack_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } state_t;

  function automatic int word_width(input int chunk_w, input int chunks);
    return chunk_w * chunks;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ram_pack_writer_chunk_packer.sv
// Assembles incoming chunks into one RAM word; flags the cycle in which a word completes.
module chunk_packer
  import ram_pack_pkg::*;
#(
  parameter int CHUNK_W         = 4,
  parameter int CHUNKS_PER_WORD = 2,
  parameter int MSB_FIRST       = 1,
  parameter int WORD_W          = word_width(CHUNK_W, CHUNKS_PER_WORD)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               accept,
  input  logic               flush_req,
  input  logic [CHUNK_W-1:0] data,
  output logic               word_done,
  output logic [WORD_W-1:0]  word
);

  localparam int SLOT_W = $clog2(CHUNKS_PER_WORD);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHUNKS_PER_WORD - 1);

  logic [SLOT_W-1:0] slot;
  logic [WORD_W-1:0] partial;
  logic [WORD_W-1:0] merged;

  // merged already contains the current chunk, so a flush alongside en includes it
  always_comb begin
    merged = partial;
    if (accept) begin
      for (int i = 0; i < CHUNKS_PER_WORD; i++) begin
        if (slot == SLOT_W'(i))
          merged[(MSB_FIRST != 0 ? WORD_W - CHUNK_W*(i+1) : CHUNK_W*i) +: CHUNK_W] = data;
      end
    end
  end

  assign word_done = (accept && slot == LAST_SLOT) ||
                     (flush_req && (accept || slot != '0));
  assign word = merged;

  always_ff @(posedge clk) begin
    if (reset || clear || word_done) begin
      slot    <= '0;
      partial <= '0;
    end else if (accept) begin
      slot    <= slot + 1'b1;
      partial <= merged;
    end
  end

endmodule

// File: rtl/ram_pack_writer.sv
// Packs chunk stream into RAM words with auto-incrementing address, stop/wrap modes and status.
//   state  | meaning
//   IDLE   | not armed; chunks dropped and flagged as overflow
//   ACTIVE | packing chunks and issuing writes
//   FULL   | stop mode, DEPTH words written; chunks dropped and flagged
module ram_pack_writer
  import ram_pack_pkg::*;
#(
  parameter  int CHUNK_W         = 4,
  parameter  int CHUNKS_PER_WORD = 2,
  parameter  int DEPTH           = 32,
  parameter  int ADDR_W          = 5,
  parameter  int MSB_FIRST       = 1,
  localparam int WORD_W          = word_width(CHUNK_W, CHUNKS_PER_WORD),
  localparam int CNT_W           = count_width(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               wrap_mode,
  input  logic               en,
  input  logic [CHUNK_W-1:0] data,
  input  logic               flush,
  output logic [ADDR_W-1:0]  waddr,
  output logic [WORD_W-1:0]  din,
  output logic               we,
  output logic               full,
  output logic               overflow,
  output logic [CNT_W-1:0]   count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  MAX_COUNT = CNT_W'(DEPTH);

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic                wrap_q;
  logic                accept;
  logic                flush_req;
  logic                word_done;
  logic [WORD_W-1:0]   word;

  // start takes priority over a coincident chunk or flush
  assign accept    = (state == ACTIVE) && en && !start;
  assign flush_req = (state == ACTIVE) && flush && !start;

  chunk_packer #(
    .CHUNK_W         (CHUNK_W),
    .CHUNKS_PER_WORD (CHUNKS_PER_WORD),
    .MSB_FIRST       (MSB_FIRST),
    .WORD_W          (WORD_W)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start),
    .accept    (accept),
    .flush_req (flush_req),
    .data      (data),
    .word_done (word_done),
    .word      (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      wrap_q   <= 1'b0;
      waddr    <= '0;
      din      <= '0;
      we       <= 1'b0;
      full     <= 1'b0;
      overflow <= 1'b0;
      count    <= '0;
    end else begin
      we <= 1'b0;
      if (start) begin
        state    <= ACTIVE;
        ptr      <= '0;
        count    <= '0;
        full     <= 1'b0;
        overflow <= 1'b0;
        wrap_q   <= wrap_mode;
      end else begin
        if (en && state != ACTIVE)
          overflow <= 1'b1;
        if (word_done) begin
          we    <= 1'b1;
          din   <= word;
          waddr <= ptr;
          ptr   <= (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
          if (count != MAX_COUNT)
            count <= count + 1'b1;
          if (!wrap_q && ptr == LAST_ADDR) begin
            state <= FULL;
            full  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_pack_writer.sv
// Bench for ram_pack_writer: default build (A) and a 4-chunk LSB-first, 8-deep build (B).
module tb_ram_pack_writer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       a_start = 0, a_wrap = 0, a_en = 0, a_flush = 0;
  logic [3:0] a_data = 0;
  logic [4:0] a_waddr;
  logic [7:0] a_din;
  logic       a_we, a_full, a_ovf;
  logic [5:0] a_count;

  logic       b_start = 0, b_wrap = 0, b_en = 0, b_flush = 0;
  logic [3:0] b_data = 0;
  logic [2:0] b_waddr;
  logic [15:0] b_din;
  logic       b_we, b_full, b_ovf;
  logic [3:0] b_count;

  ram_pack_writer dut_a (
    .clk(clk), .reset(reset), .start(a_start), .wrap_mode(a_wrap), .en(a_en),
    .data(a_data), .flush(a_flush), .waddr(a_waddr), .din(a_din), .we(a_we),
    .full(a_full), .overflow(a_ovf), .count(a_count)
  );

  ram_pack_writer #(.CHUNK_W(4), .CHUNKS_PER_WORD(4), .DEPTH(8), .ADDR_W(3), .MSB_FIRST(0)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .wrap_mode(b_wrap), .en(b_en),
    .data(b_data), .flush(b_flush), .waddr(b_waddr), .din(b_din), .we(b_we),
    .full(b_full), .overflow(b_ovf), .count(b_count)
  );

  int total = 0;
  int bad = 0;

  // reference model: per build, the list of chunks received so far plus status
  localparam int CW = 4;
  int P_CPW[2]   = '{2, 4};
  int P_DEPTH[2] = '{32, 8};
  int P_MSB[2]   = '{1, 0};

  int m_state[2];   // 0 idle, 1 active, 2 full
  int m_ch[2][4];
  int m_n[2];
  int m_ptr[2], m_count[2], m_full[2], m_ovf[2], m_wrap[2];
  int m_we[2], m_waddr[2], m_din[2];

  function automatic int pack(input int id);
    int w = 0;
    for (int i = 0; i < m_n[id]; i++) begin
      int sh;
      sh = (P_MSB[id] != 0) ? CW * (P_CPW[id] - 1 - i) : CW * i;
      w = w | (m_ch[id][i] << sh);
    end
    return w;
  endfunction

  task automatic model_step(input int id, input bit rst, input bit st, input bit wm,
                            input bit e, input int d, input bit f);
    if (rst) begin
      m_state[id] = 0; m_n[id] = 0; m_ptr[id] = 0; m_count[id] = 0;
      m_full[id] = 0; m_ovf[id] = 0; m_we[id] = 0; m_waddr[id] = 0; m_din[id] = 0;
      m_wrap[id] = 0;
    end else begin
      m_we[id] = 0;
      if (st) begin
        m_state[id] = 1; m_n[id] = 0; m_ptr[id] = 0; m_count[id] = 0;
        m_full[id] = 0; m_ovf[id] = 0; m_wrap[id] = wm;
      end else if (m_state[id] == 1) begin
        if (e) begin
          m_ch[id][m_n[id]] = d;
          m_n[id]++;
        end
        if (m_n[id] == P_CPW[id] || (f && m_n[id] > 0)) begin
          m_we[id] = 1;
          m_din[id] = pack(id);
          m_waddr[id] = m_ptr[id];
          if (m_wrap[id] == 0 && m_ptr[id] == P_DEPTH[id] - 1) begin
            m_full[id] = 1;
            m_state[id] = 2;
          end
          m_ptr[id] = (m_ptr[id] + 1) % P_DEPTH[id];
          if (m_count[id] < P_DEPTH[id]) m_count[id]++;
          m_n[id] = 0;
        end
      end else if (e) begin
        m_ovf[id] = 1;
      end
    end
  endtask

  function automatic logic [21:0] exp_a();
    return {1'(m_we[0]), 5'(m_waddr[0]), 8'(m_din[0]), 1'(m_full[0]), 1'(m_ovf[0]), 6'(m_count[0])};
  endfunction

  function automatic logic [25:0] exp_b();
    return {1'(m_we[1]), 3'(m_waddr[1]), 16'(m_din[1]), 1'(m_full[1]), 1'(m_ovf[1]), 4'(m_count[1])};
  endfunction

  logic [21:0] obs_a;
  logic [25:0] obs_b;
  assign obs_a = {a_we, a_waddr, a_din, a_full, a_ovf, a_count};
  assign obs_b = {b_we, b_waddr, b_din, b_full, b_ovf, b_count};

  task automatic tick();
    model_step(0, reset, a_start, a_wrap, a_en, int'(a_data), a_flush);
    model_step(1, reset, b_start, b_wrap, b_en, int'(b_data), b_flush);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; tick(); reset = 0;
    total++;
    if (obs_a !== exp_a()) begin bad++; $display("FAIL reset_a got=%h exp=%h", obs_a, exp_a()); end
    total++;
    if (obs_b !== exp_b()) begin bad++; $display("FAIL reset_b got=%h exp=%h", obs_b, exp_b()); end
    total++;
    if ({a_we, a_waddr, a_din, a_count, a_full, a_ovf} !== 22'd0) begin
      bad++; $display("FAIL reset_zero got=%h exp=0", {a_we, a_waddr, a_din, a_count, a_full, a_ovf});
    end
    a_flush = 1; tick(); a_flush = 0;
    total++;
    if (a_we !== 1'b0) begin bad++; $display("FAIL idle_flush we got=%b exp=0", a_we); end
    a_en = 1; a_data = 4'h3; tick(); a_en = 0;
    total++;
    if (a_ovf !== 1'b1 || a_we !== 1'b0) begin
      bad++; $display("FAIL idle_ovf got ovf=%b we=%b exp ovf=1 we=0", a_ovf, a_we);
    end
  endtask

  task automatic test_basic();
    int ch[4] = '{4'hA, 4'h5, 4'h3, 4'hC};
    a_start = 1; a_wrap = 0; tick(); a_start = 0;
    total++;
    if (a_ovf !== 1'b0) begin bad++; $display("FAIL start_clears_ovf got=%b exp=0", a_ovf); end
    for (int i = 0; i < 4; i++) begin
      a_en = 1; a_data = 4'(ch[i]); tick();
      total++;
      if (obs_a !== exp_a()) begin bad++; $display("FAIL basic_cyc%0d got=%h exp=%h", i, obs_a, exp_a()); end
      if (i == 1) begin
        total++;
        if ({a_we, a_waddr, a_din} !== {1'b1, 5'd0, 8'hA5}) begin
          bad++; $display("FAIL basic_w0 got=%b/%h/%h exp=1/00/a5", a_we, a_waddr, a_din);
        end
      end
      if (i == 3) begin
        total++;
        if ({a_we, a_waddr, a_din} !== {1'b1, 5'd1, 8'h3C}) begin
          bad++; $display("FAIL basic_w1 got=%b/%h/%h exp=1/01/3c", a_we, a_waddr, a_din);
        end
      end
    end
    a_en = 0; tick();
    total++;
    if (a_we !== 1'b0 || a_count !== 6'd2) begin
      bad++; $display("FAIL basic_end got we=%b count=%0d exp we=0 count=2", a_we, a_count);
    end
  endtask

  task automatic test_stop_full();
    a_start = 1; a_wrap = 0; tick(); a_start = 0;
    for (int i = 0; i < 64; i++) begin
      a_en = 1; a_data = 4'($urandom_range(0, 15)); tick();
      total++;
      if (obs_a !== exp_a()) begin bad++; $display("FAIL stop_cyc%0d got=%h exp=%h", i, obs_a, exp_a()); end
    end
    total++;
    if ({a_we, a_waddr, a_full, a_count} !== {1'b1, 5'd31, 1'b1, 6'd32}) begin
      bad++; $display("FAIL stop_last got we=%b waddr=%0d full=%b count=%0d exp 1/31/1/32", a_we, a_waddr, a_full, a_count);
    end
    a_data = 4'h6; tick(); a_en = 0;
    total++;
    if (a_ovf !== 1'b1 || a_we !== 1'b0) begin
      bad++; $display("FAIL stop_ovf got ovf=%b we=%b exp ovf=1 we=0", a_ovf, a_we);
    end
    a_flush = 1; tick(); a_flush = 0;
    total++;
    if (obs_a !== exp_a() || a_we !== 1'b0) begin bad++; $display("FAIL full_flush got=%h exp=%h", obs_a, exp_a()); end
  endtask

  task automatic test_wrap();
    a_start = 1; a_wrap = 1; tick(); a_start = 0;
    for (int i = 0; i < 66; i++) begin
      a_en = 1; a_data = 4'($urandom_range(0, 15)); tick();
      total++;
      if (obs_a !== exp_a()) begin bad++; $display("FAIL wrap_cyc%0d got=%h exp=%h", i, obs_a, exp_a()); end
    end
    a_en = 0;
    total++;
    if ({a_we, a_waddr, a_count, a_full, a_ovf} !== {1'b1, 5'd0, 6'd32, 1'b0, 1'b0}) begin
      bad++; $display("FAIL wrap_33rd got we=%b waddr=%0d count=%0d full=%b ovf=%b exp 1/0/32/0/0",
                      a_we, a_waddr, a_count, a_full, a_ovf);
    end
  endtask

  task automatic test_flush();
    a_start = 1; a_wrap = 0; tick(); a_start = 0;
    a_en = 1; a_data = 4'h1; tick(); a_data = 4'h2; tick();
    a_data = 4'h7; tick(); a_en = 0;
    a_flush = 1; tick();
    total++;
    if ({a_we, a_waddr, a_din} !== {1'b1, 5'd1, 8'h70}) begin
      bad++; $display("FAIL flush_partial got=%b/%h/%h exp=1/01/70", a_we, a_waddr, a_din);
    end
    tick();
    total++;
    if (a_we !== 1'b0) begin bad++; $display("FAIL flush_lone we got=%b exp=0", a_we); end
    a_en = 1; a_data = 4'h9; tick(); a_en = 0; a_flush = 0;
    total++;
    if ({a_we, a_waddr, a_din} !== {1'b1, 5'd2, 8'h90}) begin
      bad++; $display("FAIL flush_with_en got=%b/%h/%h exp=1/02/90", a_we, a_waddr, a_din);
    end
    for (int i = 0; i < 100; i++) begin
      a_start = ($urandom_range(0, 19) == 0);
      a_wrap  = 1'($urandom_range(0, 1));
      a_en    = 1'($urandom_range(0, 1));
      a_flush = ($urandom_range(0, 3) == 0);
      a_data  = 4'($urandom_range(0, 15));
      tick();
      total++;
      if (obs_a !== exp_a()) begin bad++; $display("FAIL rand_a_cyc%0d got=%h exp=%h", i, obs_a, exp_a()); end
    end
    a_start = 0; a_en = 0; a_flush = 0;
  endtask

  task automatic test_reset_mid();
    a_start = 1; a_wrap = 0; tick(); a_start = 0;
    a_en = 1; a_data = 4'hF; tick(); a_en = 0;
    reset = 1; tick(); reset = 0;
    total++;
    if (obs_a !== exp_a()) begin bad++; $display("FAIL midreset got=%h exp=%h", obs_a, exp_a()); end
    a_start = 1; tick(); a_start = 0;
    a_en = 1; a_data = 4'h1; tick();
    total++;
    if (a_we !== 1'b0) begin bad++; $display("FAIL midreset_early we got=%b exp=0", a_we); end
    a_data = 4'h2; tick(); a_en = 0;
    total++;
    if ({a_we, a_waddr, a_din} !== {1'b1, 5'd0, 8'h12}) begin
      bad++; $display("FAIL midreset_w got=%b/%h/%h exp=1/00/12", a_we, a_waddr, a_din);
    end
  endtask

  task automatic test_lsb_wide();
    b_start = 1; b_wrap = 0; tick(); b_start = 0;
    for (int i = 1; i <= 4; i++) begin
      b_en = 1; b_data = 4'(i); tick();
      total++;
      if (obs_b !== exp_b()) begin bad++; $display("FAIL b_cyc%0d got=%h exp=%h", i, obs_b, exp_b()); end
    end
    b_en = 0;
    total++;
    if ({b_we, b_waddr, b_din} !== {1'b1, 3'd0, 16'h4321}) begin
      bad++; $display("FAIL b_word got=%b/%h/%h exp=1/0/4321", b_we, b_waddr, b_din);
    end
    b_start = 1; b_en = 1; b_data = 4'hE; tick(); b_start = 0;
    total++;
    if (b_ovf !== 1'b0 || b_count !== 4'd0) begin
      bad++; $display("FAIL b_start_en got ovf=%b count=%0d exp ovf=0 count=0", b_ovf, b_count);
    end
    for (int i = 5; i <= 8; i++) begin
      b_data = 4'(i); tick();
    end
    b_en = 0;
    total++;
    if ({b_we, b_waddr, b_din} !== {1'b1, 3'd0, 16'h8765}) begin
      bad++; $display("FAIL b_drop got=%b/%h/%h exp=1/0/8765", b_we, b_waddr, b_din);
    end
    for (int i = 0; i < 150; i++) begin
      b_start = ($urandom_range(0, 29) == 0);
      b_wrap  = 1'($urandom_range(0, 1));
      b_en    = ($urandom_range(0, 3) != 0);
      b_flush = ($urandom_range(0, 7) == 0);
      b_data  = 4'($urandom_range(0, 15));
      tick();
      total++;
      if (obs_b !== exp_b()) begin bad++; $display("FAIL rand_b_cyc%0d got=%h exp=%h", i, obs_b, exp_b()); end
    end
    b_start = 0; b_en = 0; b_flush = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stop_full();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_lsb_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
